// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter: shares one device port between host 0 (IFU) and host 1 (LSU).
// Round-robin A-channel grant with locking, in-order host-ID FIFO for response routing.

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  tl_h2d_t         tl_h0_i,
    output tl_d2h_t         tl_h0_o,
    input  tl_h2d_t         tl_h1_i,
    output tl_d2h_t         tl_h1_o,
    output tl_h2d_t         tl_dev_o,
    input  tl_d2h_t         tl_dev_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            unexp_rsp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Host-ID FIFO (0 = host 0, 1 = host 1) and tracking state
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      lock_q, lock_d;
    logic                      lock_host_q, lock_host_d;
    logic                      last_winner_q, last_winner_d;
    logic                      unexp_q, unexp_d;

    logic    full, empty;
    logic    gnt;
    tl_h2d_t gnt_req;
    logic    a_open;
    logic    dev_a_valid, a_hs;
    logic    head, head_d_ready;
    logic    dev_d_ready, d_hs;
    logic    stray;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CntW'(MaxOutstanding));
    assign empty = (cnt_q == '0);

    // Grant selection: locked host first, else single requester, else the non-last winner
    always_comb begin
        gnt = ~last_winner_q;
        if (lock_q) begin
            gnt = lock_host_q;
        end else if (tl_h0_i.a_valid && !tl_h1_i.a_valid) begin
            gnt = 1'b0;
        end else if (!tl_h0_i.a_valid && tl_h1_i.a_valid) begin
            gnt = 1'b1;
        end
    end

    assign gnt_req     = gnt ? tl_h1_i : tl_h0_i;
    // A channel is closed while full or held in reset
    assign a_open      = !full && !reset;
    assign dev_a_valid = a_open && gnt_req.a_valid;
    assign a_hs        = dev_a_valid && tl_dev_i.a_ready;

    assign head         = fifo_q[rd_ptr_q];
    assign head_d_ready = head ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    // With nothing outstanding, accept and drop anything the device sends
    assign dev_d_ready  = reset ? 1'b0 : (empty ? 1'b1 : head_d_ready);
    assign d_hs         = !empty && tl_dev_i.d_valid && dev_d_ready;
    assign stray        = empty && tl_dev_i.d_valid && !reset;

    // Output muxing: device sees the granted host, D channel goes to the FIFO head
    always_comb begin
        tl_dev_o         = gnt_req;
        tl_dev_o.a_valid = dev_a_valid;
        tl_dev_o.d_ready = dev_d_ready;

        tl_h0_o          = tl_dev_i;
        tl_h0_o.a_ready  = a_open && !gnt && tl_dev_i.a_ready;
        tl_h0_o.d_valid  = !reset && !empty && !head && tl_dev_i.d_valid;

        tl_h1_o          = tl_dev_i;
        tl_h1_o.a_ready  = a_open && gnt && tl_dev_i.a_ready;
        tl_h1_o.d_valid  = !reset && !empty && head && tl_dev_i.d_valid;
    end

    // Next-state for FIFO, counter, grant lock and sticky error
    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        lock_d        = lock_q;
        lock_host_d   = lock_host_q;
        last_winner_d = last_winner_q;
        unexp_d       = unexp_q | stray;

        if (a_hs) begin
            fifo_d[wr_ptr_q] = gnt;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            last_winner_d    = gnt;
            lock_d           = 1'b0;
        end else if (dev_a_valid && !tl_dev_i.a_ready) begin
            // Hold the grant so the presented request stays stable until accepted
            lock_d      = 1'b1;
            lock_host_d = gnt;
        end

        if (d_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({a_hs, d_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; host 0 wins the first tie after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            lock_q        <= 1'b0;
            lock_host_q   <= 1'b0;
            last_winner_q <= 1'b1;
            unexp_q       <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            lock_q        <= lock_d;
            lock_host_q   <= lock_host_d;
            last_winner_q <= last_winner_d;
            unexp_q       <= unexp_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign unexp_rsp_o   = unexp_q;

endmodule
